// File: rtl/trig_pkg.sv
// Shared definitions for the trigger generator / decoder pair: FSM states,
// default accumulator width and the divider iteration count.
package trig_pkg;

    localparam int NUM_BITS_DEF = 32;
    localparam int DIV_ITERS    = NUM_BITS_DEF + 1;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2
    } trig_state_t;

    // One quotient bit per dividend bit; the dividend 2^num_bits has num_bits+1 bits.
    function automatic int div_iters(input int num_bits);
        return num_bits + 1;
    endfunction

endpackage

// File: rtl/recip_div.sv
// Multi-cycle restoring divider computing floor(2^NUM_BITS / divisor),
// one quotient bit per clk, with start/busy/done handshake and abort.
module recip_div
    import trig_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEF,
    parameter int DIV_BITS = 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [DIV_BITS-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] quotient
);

    localparam int ITERS = div_iters(NUM_BITS);
    localparam int IW    = $clog2(ITERS);
    localparam logic [IW-1:0] LAST_ITER = IW'(ITERS - 1);

    logic [DIV_BITS-1:0] div_q;
    logic [DIV_BITS-1:0] rem;
    logic [DIV_BITS-1:0] rem_next;
    logic [DIV_BITS:0]   trial;
    logic [DIV_BITS:0]   diff;
    logic                q_bit;
    logic [NUM_BITS-1:0] quo;
    logic [NUM_BITS-1:0] quo_next;
    logic [IW-1:0]       iter;

    // The only set dividend bit is the MSB, fed in on the first iteration.
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        trial    = {rem, (iter == '0)};
        diff     = trial - {1'b0, div_q};
        q_bit    = (trial >= {1'b0, div_q});
        rem_next = q_bit ? diff[DIV_BITS-1:0] : trial[DIV_BITS-1:0];
        quo_next = {quo[NUM_BITS-2:0], q_bit};
    end

    // The final quotient bit is resolved combinationally so the caller can
    // register the result on the same edge that retires the last iteration.
    assign done     = busy && (iter == LAST_ITER);
    assign quotient = quo_next;

    // NOTE: datapath registers are loaded on start, so only control state is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            iter <= '0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start && !busy) begin
            busy  <= 1'b1;
            iter  <= '0;
            rem   <= '0;
            quo   <= '0;
            div_q <= divisor;
        end else if (busy) begin
            rem  <= rem_next;
            quo  <= quo_next;
            iter <= iter + IW'(1);
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/trig_decode.sv
// Trigger-rate decoder: measures the rising-edge period of `trigger` in
// trig_en ticks and recovers the generator tuning word floor(2^NUM_BITS/period).
module trig_decode
    import trig_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEF,
    parameter int CNT_BITS = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trig_en,
    input  logic                trigger,
    output logic [NUM_BITS-1:0] tuning_word,
    output logic                valid,
    output logic                locked,
    output logic                busy
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    trig_state_t         state;
    logic                trig_d;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS:0]   period;
    logic                rise;
    logic                timeout;
    logic                div_start;
    logic                div_done;
    logic [NUM_BITS-1:0] div_quot;

    assign rise      = trig_en && trigger && !trig_d;
    assign timeout   = trig_en && !rise && (cnt == CNT_MAX) && (state != HUNT);
    // One bit wider than cnt so a saturated count still yields the true period.
    assign period    = {1'b0, cnt} + (CNT_BITS + 1)'(1);
    assign div_start = (state == MEASURE) && rise;

    recip_div #(
        .NUM_BITS (NUM_BITS),
        .DIV_BITS (CNT_BITS + 1)
    ) u_recip_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .abort    (timeout),
        .divisor  (period),
        .busy     (busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    // NOTE: state and output registers use non-blocking assignments so every
    // term on the right-hand side reads its pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            trig_d      <= 1'b1;
            cnt         <= '0;
            tuning_word <= '0;
            valid       <= 1'b0;
            locked      <= 1'b0;
        end else begin
            valid <= 1'b0;

            if (trig_en)
                trig_d <= trigger;

            if (rise)
                cnt <= '0;
            else if (trig_en && (cnt != CNT_MAX))
                cnt <= cnt + CNT_BITS'(1);

            if (timeout) begin
                state       <= HUNT;
                tuning_word <= '0;
                locked      <= 1'b0;
                valid       <= 1'b1;
            end else begin
                unique case (state)
                    HUNT: begin
                        if (rise)
                            state <= MEASURE;
                    end
                    MEASURE: begin
                        if (rise)
                            state <= DIVIDE;
                    end
                    DIVIDE: begin
                        // Edges seen here only restart cnt; their period is dropped.
                        if (div_done) begin
                            tuning_word <= div_quot;
                            valid       <= 1'b1;
                            locked      <= 1'b1;
                            state       <= MEASURE;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trig_decode.sv
// Scoreboard bench for trig_decode: a tick-level reference model predicts every
// valid pulse, tuning word, lock and busy window; a monitor checks each clk.
module tb_trig_decode;

    localparam int NB  = 32;
    localparam int CB  = 8;
    localparam int SAT = (1 << CB) - 1;

    typedef struct {
        int          due;
        logic [31:0] word;
        logic        lck;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trig_en = 1'b0;
    logic          trigger = 1'b0;
    logic [NB-1:0] tuning_word;
    logic          valid;
    logic          locked;
    logic          busy;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic rst_seen = 1'b0;
    logic mon_on   = 1'b0;

    exp_t        q[$];
    logic [31:0] exp_tw     = '0;
    logic        exp_locked = 1'b0;
    logic        mon_exp_v;

    // Reference model state, in terms of tick indices rather than counters.
    logic        m_hunting  = 1'b1;
    logic        m_prev_trg = 1'b1;
    int          m_tick     = 0;
    int          m_last_edge = 0;
    int          m_div_done = 0;
    int          busy_from  = 1;
    int          busy_to    = 0;
    int          last_start = -1;
    logic [31:0] acc;

    trig_decode #(
        .NUM_BITS (NB),
        .CNT_BITS (CB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trig_en     (trig_en),
        .trigger     (trigger),
        .tuning_word (tuning_word),
        .valid       (valid),
        .locked      (locked),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] recip(input int period);
        logic [63:0] r;
        r = (64'd1 << NB) / 64'(period);
        return r[31:0];
    endfunction

    task automatic model_reset(input int c);
        while (q.size() > 0 && q[$].due > c)
            void'(q.pop_back());
        if (busy_to > c)
            busy_to = c;
        m_hunting   = 1'b1;
        m_prev_trg  = 1'b1;
        m_tick      = 0;
        m_last_edge = 0;
        m_div_done  = 0;
    endtask

    task automatic model_tick(input int c, input logic en, input logic trg);
        logic rising;
        int   period;
        if (!en)
            return;
        m_tick++;
        rising     = trg && !m_prev_trg;
        m_prev_trg = trg;
        if (rising) begin
            period      = m_tick - m_last_edge;
            m_last_edge = m_tick;
            if (m_hunting) begin
                m_hunting = 1'b0;
            end else if (c >= m_div_done) begin
                q.push_back('{due: c + NB + 2, word: recip(period), lck: 1'b1});
                m_div_done = c + NB + 2;
                busy_from  = c + 1;
                busy_to    = c + NB + 1;
                last_start = c;
            end
        end else if (!m_hunting && (m_tick - 1 - m_last_edge) >= SAT) begin
            if (c < m_div_done) begin
                void'(q.pop_back());
                busy_to    = c;
                m_div_done = 0;
            end
            q.push_back('{due: c + 1, word: 32'd0, lck: 1'b0});
            m_hunting = 1'b1;
        end
    endtask

    task automatic step(input logic en, input logic trg, input logic r);
        @(posedge clk);
        #1;
        rst     = r;
        trig_en = en;
        trigger = trg;
        if (r)
            model_reset(cyc);
        else
            model_tick(cyc, en, trg);
    endtask

    // Fixed duty pattern: `ones` high ticks then low ticks, `len` ticks per period.
    task automatic pat_run(input int ones, input int len, input int n, input int every);
        int   phase = 0;
        logic trg;
        for (int k = 0; k < n; k++) begin
            if (k % every == 0) begin
                trg   = (phase < ones);
                phase = (phase + 1) % len;
                step(1'b1, trg, 1'b0);
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
    endtask

    // Phase-accumulator generator; density>0 selects random tick spacing.
    task automatic gen_run(input logic [31:0] word, input int n, input int every, input int density);
        logic en;
        acc = '0;
        for (int k = 0; k < n; k++) begin
            en = (density > 0) ? ($urandom_range(1, 100) <= density) : (k % every == 0);
            if (en) begin
                acc = acc + word;
                step(1'b1, acc[31], 1'b0);
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (rst_seen) begin
                exp_tw     = '0;
                exp_locked = 1'b0;
            end
            mon_exp_v = (q.size() > 0) && (q[0].due == cyc);
            check("valid", 64'(valid), 64'(mon_exp_v));
            if (mon_exp_v) begin
                exp_tw     = q[0].word;
                exp_locked = q[0].lck;
                void'(q.pop_front());
            end
            check("tuning_word", 64'(tuning_word), 64'(exp_tw));
            check("locked", 64'(locked), 64'(exp_locked));
            check("busy", 64'(busy), 64'(cyc >= busy_from && cyc <= busy_to));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   mark;
        logic found;
        int   phase;

        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        mon_on = 1'b1;
        check("reset_tuning_word", 64'(tuning_word), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_locked", 64'(locked), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        gen_run(32'h4000_0000, 150, 1, 0);
        pat_run(1, 3, 200, 1);
        gen_run(32'h4000_0000, 400, 5, 0);

        // Hold trigger low long enough to time out, then relock.
        pat_run(0, 1, 300, 1);
        pat_run(2, 4, 100, 1);

        pat_run(1, 2, 250, 1);

        for (int s = 0; s < 6; s++)
            gen_run($urandom_range(32'h0150_0000, 32'h7FFF_FFFF), 500, 1, $urandom_range(30, 100));

        // Reset in cycle E+10 of a divide.
        pat_run(2, 4, 60, 1);
        mark  = last_start;
        found = 1'b0;
        phase = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            step(1'b1, (phase < 2), 1'b0);
            phase = (phase + 1) % 4;
            if (last_start > mark && cyc == last_start + 9)
                found = 1'b1;
        end
        check("divide_started", 64'(found), 64'd1);
        if (found) begin
            step(1'b1, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
            check("rst_mid_tuning_word", 64'(tuning_word), 64'd0);
            check("rst_mid_valid", 64'(valid), 64'd0);
            check("rst_mid_locked", 64'(locked), 64'd0);
            check("rst_mid_busy", 64'(busy), 64'd0);
        end

        pat_run(2, 4, 120, 1);
        for (int k = 0; k < 40; k++)
            step(1'b0, 1'b0, 1'b0);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trig_decode.md
# trig_decode

Receive-side counterpart of the synthesizer's trigger generator. It samples a square-wave `trigger` on the shared `trig_en` tick and measures the rising-edge period in ticks. It recovers the equivalent phase-accumulator tuning word as floor(2^NUM_BITS / period) using a multi-cycle restoring divider. It sits on the modulation/sync path wherever a block must lock to an externally generated or looped-back trigger rate.

## Interface
- NUM_BITS, 32, width of the recovered tuning word; matches the generator accumulator width
- CNT_BITS, 24, width of the period counter; its all-ones value is the timeout
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- trig_en  in  1  sample tick; `trigger` is only examined when high
- trigger  in  1  square-wave trigger (generator accumulator MSB)
- tuning_word  out  NUM_BITS  last recovered tuning word; held between updates
- valid  out  1  one-clk pulse when `tuning_word` updates
- locked  out  1  high after the first successful measurement; low after reset or timeout
- busy  out  1  high while the divider runs

## Operation
- Edge detect:
  - `trig_d` is updated from `trigger` only on `trig_en` cycles; reset value 1.
  - An edge is a cycle with trig_en=1, trigger=1 and trig_d=0.
- Period counter `cnt` (CNT_BITS):
  - On an edge tick, `cnt` clears to 0.
  - On a non-edge `trig_en` tick, `cnt` increments, saturating at all-ones.
  - `cnt` keeps running in every state.
- State machine: HUNT, MEASURE, DIVIDE.
  - HUNT (reset state): an edge clears `cnt` and moves to MEASURE. No result is produced.
  - MEASURE: an edge latches period = cnt+1 into the divisor register, clears `cnt`, and moves to DIVIDE.
  - DIVIDE: runs for exactly NUM_BITS+1 clk cycles, one quotient bit per cycle, dividend 2^NUM_BITS. On completion, `tuning_word` takes the quotient's low NUM_BITS bits, `valid` pulses, `locked` is set to 1, and the state returns to MEASURE.
  - An edge arriving during DIVIDE still clears `cnt`. Its period is discarded (no result) and the divide in progress completes normally.
- Timeout: a non-edge tick with `cnt` already all-ones, in MEASURE or DIVIDE, does the following:
  - moves to HUNT and aborts any divide;
  - sets `tuning_word` to 0 and `locked` to 0;
  - pulses `valid` once.
  - In HUNT, saturation has no effect.
- Arithmetic:
  - The period is at least 2 by construction, so the quotient is at most 2^(NUM_BITS-1) and fits without saturation.
  - The divisor register is CNT_BITS+1 bits wide so that cnt+1 at saturation does not wrap.
- `trig_en` held low: nothing advances except an in-flight divide.

## Timing
- Reset values: tuning_word=0, valid=0, locked=0, busy=0, state=HUNT, cnt=0, trig_d=1.
- Let E be the clk cycle in which a MEASURE edge is sampled.
  - `busy` is high in cycles E+1 through E+NUM_BITS+1.
  - `tuning_word` and `valid` are updated in cycle E+NUM_BITS+2, so latency is NUM_BITS+2 clk.
- `valid` is exactly one cycle wide; `tuning_word` is stable until the next `valid`.
- Timeout: `valid`, `locked`=0 and `tuning_word`=0 appear the cycle after the timeout tick. `busy` drops in that same cycle.
- `rst` mid-divide aborts the divide with no `valid` pulse. All outputs take their reset values the next cycle.
- Measurement resolution is one `trig_en` tick. The result equals the generator word only when 2^NUM_BITS / word is an integer; otherwise it is within the floor-division error.

## Structure
- Shared package `trig_pkg`:
  - the state enum (HUNT, MEASURE, DIVIDE);
  - the default NUM_BITS, shared with the generator;
  - the localparam for the divider iteration count (NUM_BITS+1).
- Sub-module `recip_div` is a restoring divider computing floor(2^NUM_BITS / divisor).
  - Interface: start/busy/done handshake plus a synchronous abort input.
  - This top-level module owns the edge detect, counter, FSM and output registers.

## Test plan
- Reset, then drive trigger from a generator with word 0x4000_0000 and trig_en every clk (period 4).
  - The first edge produces no `valid`.
  - The second edge gives `valid` 34 clk later with tuning_word=0x4000_0000 and locked=1.
- Period 3 pattern (trigger 1,0,0 repeating): tuning_word=0x5555_5555 at each `valid`.
- trig_en every 5th clk with a period-4 pattern: same 0x4000_0000 result; `cnt` advances only on ticks.
- Set CNT_BITS=8 and, once locked, hold trigger low:
  - after 255 ticks plus one, `valid` pulses with tuning_word=0, locked=0 and state HUNT;
  - the next two edges relock.
- Period-2 pattern with trig_en every clk:
  - edges arriving during DIVIDE are discarded;
  - every `valid` carries 0x8000_0000;
  - `valid` never pulses twice within 33 clk.
- Assert `rst` in cycle E+10 of a divide: no `valid`, and all outputs are at reset values the next cycle.
